sram_req_bridge: RTL and testbench

- Upstream front-end for the 4 KiB-word SRAM wrapper: converts a valid/ready request/response bus from the core or load-store unit into SRAM port signals.
- SRAM port signals: active-low chip select, active-low write enable, byte mask, word address, write data.
- Captures SRAM read data at a fixed latency into a response FIFO so the consumer can apply backpressure without losing data.
- Range/alignment errors are answered locally, in order, without touching the SRAM.

---
 rtl/sram_req_bridge.sv | 157 +++++++++++++++
 tb/tb_sram_req_bridge.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_bridge.sv
// Valid/ready request bus to single-port SRAM bridge, with in-order responses held in a
// credit-limited FIFO. Define SRAM_REQ_BRIDGE_STATS_EN to add the saturating stat_*_o counters.
module sram_req_bridge #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          READ_LAT   = 1,
    parameter int          RSP_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  sram_csb_o,
    output logic                  sram_we_o,
    output logic [3:0]            sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_wdata_o,
    input  logic [31:0]           sram_rdata_i
`ifdef SRAM_REQ_BRIDGE_STATS_EN
    ,
    output logic [15:0]           stat_rd_o,
    output logic [15:0]           stat_wr_o,
    output logic [15:0]           stat_err_o
`endif
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);

    logic [31:0]           off;
    logic                  addr_err;
    logic [ADDR_WIDTH-1:0] word;
    logic                  fire;
    logic                  push;
    logic                  pop;
    logic                  empty;
    logic [31:0]           push_data;
    logic                  unused_off_bits;

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         fifo_cnt;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [READ_LAT-1:0]   pipe_valid;
    logic [READ_LAT-1:0]   pipe_read;
    logic [READ_LAT-1:0]   pipe_err;
    logic [31:0]           fifo_data [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_err;

    assign off             = req_addr_i - BASE_ADDR;
    assign addr_err        = (req_addr_i[1:0] != 2'b00) || (off[31:ADDR_WIDTH+2] != '0);
    assign word            = off[ADDR_WIDTH+1:2];
    assign unused_off_bits = ^off[1:0];

    // Credits cover everything still owed a response, so the FIFO can never overflow.
    assign req_ready_o = !rst_i && (cnt < DEPTH_C);
    assign fire        = req_valid_i && req_ready_o;

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_wmask_o = 4'h0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (fire && !addr_err) begin
            sram_csb_o   = 1'b0;
            sram_we_o    = !req_we_i;
            sram_wmask_o = req_we_i ? req_be_i : 4'hF;
            sram_addr_o  = word;
            sram_wdata_o = req_wdata_i;
        end
    end

    assign push      = pipe_valid[READ_LAT-1];
    assign push_data = (pipe_read[READ_LAT-1] && !pipe_err[READ_LAT-1]) ? sram_rdata_i : '0;
    assign empty     = (fifo_cnt == '0);
    assign pop       = rsp_valid_o && rsp_ready_i;

    assign rsp_valid_o = !empty;
    assign rsp_rdata_o = empty ? '0 : fifo_data[rd_ptr];
    assign rsp_err_o   = !empty && fifo_err[rd_ptr];

    // Error requests ride the pipeline too, so their responses stay in order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_read  <= '0;
            pipe_err   <= '0;
        end else begin
            pipe_valid[0] <= fire;
            pipe_read[0]  <= !req_we_i;
            pipe_err[0]   <= addr_err;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_read[i]  <= pipe_read[i-1];
                pipe_err[i]   <= pipe_err[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            cnt      <= cnt + CW'(fire) - CW'(pop);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible through a non-empty head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_err[wr_ptr]  <= pipe_err[READ_LAT-1];
        end
    end

    credit_bound: assert property (@(posedge clk_i) disable iff (rst_i) cnt <= DEPTH_C);

`ifdef SRAM_REQ_BRIDGE_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_rd_o  <= '0;
            stat_wr_o  <= '0;
            stat_err_o <= '0;
        end else if (fire) begin
            if (addr_err) begin
                if (stat_err_o != 16'hFFFF) stat_err_o <= stat_err_o + 16'd1;
            end else if (req_we_i) begin
                if (stat_wr_o != 16'hFFFF) stat_wr_o <= stat_wr_o + 16'd1;
            end else begin
                if (stat_rd_o != 16'hFFFF) stat_rd_o <= stat_rd_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_bridge.sv
// Self-checking bench for sram_req_bridge: directed cases plus randomized traffic,
// checked against a transaction-level model (byte-array memory and a queue of owed responses).
module tb_sram_req_bridge;

    localparam int          ADDR_WIDTH = 12;
    localparam logic [31:0] BASE_ADDR  = 32'h0000_0000;
    localparam int          READ_LAT   = 1;
    localparam int          RSP_DEPTH  = 4;
    localparam int          WORDS      = 4096;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b0;
    logic                  req_valid_i = 1'b0;
    logic                  req_ready_o;
    logic                  req_we_i = 1'b0;
    logic [31:0]           req_addr_i = '0;
    logic [31:0]           req_wdata_i = '0;
    logic [3:0]            req_be_i = '0;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i = 1'b0;
    logic [31:0]           rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  sram_csb_o;
    logic                  sram_we_o;
    logic [3:0]            sram_wmask_o;
    logic [ADDR_WIDTH-1:0] sram_addr_o;
    logic [31:0]           sram_wdata_o;
    logic [31:0]           sram_rdata_i = '0;

    sram_req_bridge #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .BASE_ADDR (BASE_ADDR),
        .READ_LAT  (READ_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .sram_csb_o  (sram_csb_o),
        .sram_we_o   (sram_we_o),
        .sram_wmask_o(sram_wmask_o),
        .sram_addr_o (sram_addr_o),
        .sram_wdata_o(sram_wdata_o),
        .sram_rdata_i(sram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural SRAM with a one-cycle read latency.
    logic [31:0] sram_mem [WORDS] = '{default: '0};
    always @(posedge clk_i) begin
        if (!sram_csb_o) begin
            if (!sram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
            end else begin
                sram_rdata_i <= sram_mem[sram_addr_o];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] ref_mem [WORDS] = '{default: '0};
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          accepts = 0;
    int          stalls = 0;
    logic        last_fire = 1'b0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Evaluates one cycle at the negative edge: ready from credits owed, response timing
    // from each request's accept cycle, data from the reference memory.
    task automatic sampleCycle();
        logic        exp_ready;
        logic        exp_valid;
        logic        err;
        logic [31:0] off;
        logic [31:0] word;
        rsp_t        r;
        exp_ready = (exp_q.size() < RSP_DEPTH);
        exp_valid = (exp_q.size() > 0) && (exp_q[0].acc + READ_LAT + 1 <= cyc);
        checkOutput("req_ready", 32'(req_ready_o), 32'(exp_ready));
        checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
        if (req_valid_i && !req_ready_o) stalls++;
        last_fire = req_valid_i && exp_ready;
        if (last_fire) begin
            off  = req_addr_i - BASE_ADDR;
            word = off / 4;
            err  = (req_addr_i % 4 != 0) || (word >= WORDS);
            checkOutput("sram_csb", 32'(sram_csb_o), 32'(err));
            if (!err) begin
                checkOutput("sram_we", 32'(sram_we_o), 32'(!req_we_i));
                checkOutput("sram_addr", 32'(sram_addr_o), word);
                checkOutput("sram_wmask", 32'(sram_wmask_o), 32'(req_we_i ? req_be_i : 4'hF));
                checkOutput("sram_wdata", sram_wdata_o, req_wdata_i);
                if (req_we_i)
                    for (int b = 0; b < 4; b++)
                        if (req_be_i[b]) ref_mem[word][8*b +: 8] = req_wdata_i[8*b +: 8];
            end
            r.rdata = (!req_we_i && !err) ? ref_mem[word[11:0]] : 32'h0;
            r.err   = err;
            r.acc   = cyc;
            exp_q.push_back(r);
            accepts++;
        end else begin
            checkOutput("sram_idle_csb", 32'(sram_csb_o), 32'd1);
        end
        if (exp_valid && rsp_ready_i) begin
            r = exp_q.pop_front();
            checkOutput("rsp_rdata", rsp_rdata_o, r.rdata);
            checkOutput("rsp_err", 32'(rsp_err_o), 32'(r.err));
            last_rdata = rsp_rdata_o;
            last_err   = rsp_err_o;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be, input logic rdy);
        req_valid_i = valid;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        rsp_ready_i = rdy;
        @(negedge clk_i);
        sampleCycle();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic issueReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic rdy);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, we, addr, wdata, be, rdy);
            if (last_fire) break;
        end
        if (!last_fire) checkOutput("issue_timeout", 32'd0, 32'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() > 0; i++)
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    endtask

    function automatic logic [31:0] randAddr();
        int k;
        k = $urandom_range(0, 15);
        if (k == 0) return BASE_ADDR + 32'h4000 + 32'(4 * $urandom_range(0, 255));
        if (k == 1) return BASE_ADDR + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
        return BASE_ADDR + 32'(4 * $urandom_range(0, 31));
    endfunction

    initial begin
        int base;

        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err_o), 32'd0);
        checkOutput("rst_sram_csb", 32'(sram_csb_o), 32'd1);
        checkOutput("rst_sram_we", 32'(sram_we_o), 32'd1);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'(req_ready_o), 32'd1);

        // Full-word write then read back, responses held under backpressure.
        issueReq(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        issueReq(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        checkOutput("t1_read_head", rsp_rdata_o, 32'hDEADBEEF);
        drain();

        issueReq(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 1'b1);
        issueReq(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        drain();
        checkOutput("t2_byte_merge", last_rdata, 32'hDEADABEF);

        issueReq(1'b0, 32'h4000, 32'h0, 4'h0, 1'b1);
        drain();
        checkOutput("t3_range_err", 32'(last_err), 32'd1);
        issueReq(1'b0, 32'h2, 32'h0, 4'h0, 1'b1);
        drain();
        checkOutput("t3_align_err", 32'(last_err), 32'd1);
        checkOutput("t3_align_rdata", last_rdata, 32'd0);

        // Six back-to-back reads against a stalled consumer.
        base = accepts;
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 32'(4 * (i + 4)), 32'h0, 4'h0, 1'b0);
        checkOutput("t4_accepted", 32'(accepts - base), 32'd4);
        checkOutput("t4_ready_low", 32'(req_ready_o), 32'd0);
        issueReq(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        issueReq(1'b0, 32'h24, 32'h0, 4'h0, 1'b1);
        drain();

        stalls = 0;
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), randAddr(), $urandom,
                          4'($urandom_range(0, 15)), 1'b1);
        checkOutput("t5_no_stall", 32'(stalls), 32'd0);
        drain();

        for (int i = 0; i < 150; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randAddr(), $urandom,
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
        drain();

        // Reset with requests still owed.
        for (int i = 0; i < 3; i++)
            issueReq(1'b0, 32'(4 * i), 32'h0, 4'h0, 1'b0);
        rst_i = 1'b1;
        #1;
        checkOutput("t6_rst_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("t6_rst_rdata", rsp_rdata_o, 32'd0);
        checkOutput("t6_rst_csb", 32'(sram_csb_o), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        checkOutput("t6_ready_release", 32'(req_ready_o), 32'd1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        issueReq(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
